fetch_unit: RTL

- Instruction-fetch stage: the producer side of the instruction interface consumed by control_unit, which decodes op/funct3/funct7 from InstrD.
- Owns the PC and issues in-order requests to instruction memory.
- Buffers returned words and presents one instruction per cycle to Decode through the IF/ID register.
- Honours stall and flush from the hazard logic and redirects from Execute (branches and jumps).

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/fetch_buffer.sv | 58 +++++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Definitions shared by the fetch stage: word sizes, the canonical NOP,
// instruction field positions and the fetch FSM state encoding.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REDIR = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small circular FIFO of fetched {pc, instr} pairs sitting between the
// instruction-memory response port and the IF/ID register.
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_instr,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_instr,
  output logic            full,
  output logic            empty,
  output logic [CW-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];
  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order memory
// requests and feeds Decode one instruction per cycle through IF/ID.
// state | meaning
// BOOT  | first cycle after reset, no request issued
// RUN   | normal fetching while credits allow
// REDIR | one idle cycle after a redirect, PC already holds the target
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              IBUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            InstrValidD
);

  localparam int CW = $clog2(IBUF_DEPTH + 1);
  localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc, rsp_pc, head_pc, head_instr;
  logic [CW-1:0]   outstanding, drop, buf_count;
  logic            buf_full, buf_empty, buf_push, buf_pop;
  logic            credit_ok, req_fire, rsp_keep, if_kill, bypass;
  logic [XLEN-1:0] inflight_pc [IBUF_DEPTH];
  logic [PW-1:0]   inf_rd, inf_wr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(IBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Words already in the buffer count against the credit too, so a push can never overflow it.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, buf_count}) < (CW + 1)'(IBUF_DEPTH);
  assign req_fire  = imem_req_valid & imem_req_ready;
  assign rsp_pc    = inflight_pc[inf_rd];
  assign rsp_keep  = imem_rsp_valid && (drop == '0) && !PCSrcE;
  assign if_kill   = FlushD | PCSrcE;
  assign buf_pop   = !if_kill && !StallD && !buf_empty;
  assign bypass    = !if_kill && !StallD && buf_empty && rsp_keep;
  assign buf_push  = rsp_keep && !bypass;
  assign imem_req_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_BOOT;
    else     state <= state_next;
  end

  always_comb begin
    unique case (state)
      ST_BOOT, ST_RUN, ST_REDIR: state_next = ST_RUN;
      default:                   state_next = ST_BOOT;
    endcase
    if (PCSrcE) state_next = ST_REDIR;
  end

  always_comb begin
    imem_req_valid = (state == ST_RUN) && credit_ok && !PCSrcE;
  end

  always_ff @(posedge clk) begin
    if (req_fire) inflight_pc[inf_wr] <= pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= word_align(RESET_PC);
      outstanding <= '0;
      drop        <= '0;
      inf_rd      <= '0;
      inf_wr      <= '0;
    end else begin
      if (PCSrcE)        pc <= word_align(PCTargetE);
      else if (req_fire) pc <= pc + 32'd4;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      // Everything still in flight at a redirect belongs to the old path.
      if (PCSrcE)                             drop <= outstanding - CW'(imem_rsp_valid);
      else if (imem_rsp_valid && drop != '0) drop <= drop - 1'b1;
      if (req_fire)       inf_wr <= ptr_inc(inf_wr);
      if (imem_rsp_valid) inf_rd <= ptr_inc(inf_rd);
      assert (!(imem_rsp_valid && outstanding == '0));
      assert (!(buf_push && buf_full && !buf_pop));
    end
  end

  fetch_buffer #(.DEPTH(IBUF_DEPTH)) u_fetch_buffer (
    .clk        (clk),
    .rst        (rst),
    .push       (buf_push),
    .pop        (buf_pop),
    .flush      (PCSrcE),
    .push_pc    (rsp_pc),
    .push_instr (imem_rsp_data),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .full       (buf_full),
    .empty      (buf_empty),
    .count      (buf_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      InstrD      <= NOP_INSTR;
      PCD         <= '0;
      PCPlus4D    <= '0;
      InstrValidD <= 1'b0;
    end else if (if_kill) begin
      InstrD      <= NOP_INSTR;
      InstrValidD <= 1'b0;
    end else if (StallD) begin
      InstrValidD <= InstrValidD;
    end else if (!buf_empty) begin
      InstrD      <= head_instr;
      PCD         <= head_pc;
      PCPlus4D    <= head_pc + 32'd4;
      InstrValidD <= 1'b1;
    end else if (rsp_keep) begin
      InstrD      <= imem_rsp_data;
      PCD         <= rsp_pc;
      PCPlus4D    <= rsp_pc + 32'd4;
      InstrValidD <= 1'b1;
    end else begin
      InstrD      <= NOP_INSTR;
      InstrValidD <= 1'b0;
    end
  end

endmodule
